// File: rtl/alu_pkg.sv
// Function codes shared by the execute-stage ALU and its branch comparator.
package alu_pkg;

  localparam logic [5:0] FUNC_SLL  = 6'b000000;
  localparam logic [5:0] FUNC_SRL  = 6'b000010;
  localparam logic [5:0] FUNC_SRA  = 6'b000011;
  localparam logic [5:0] FUNC_JR   = 6'b001000;
  localparam logic [5:0] FUNC_ADD  = 6'b100000;
  localparam logic [5:0] FUNC_ADDU = 6'b100001;
  localparam logic [5:0] FUNC_SUB  = 6'b100010;
  localparam logic [5:0] FUNC_SUBU = 6'b100011;
  localparam logic [5:0] FUNC_AND  = 6'b100100;
  localparam logic [5:0] FUNC_OR   = 6'b100101;
  localparam logic [5:0] FUNC_XOR  = 6'b100110;
  localparam logic [5:0] FUNC_NOR  = 6'b100111;
  localparam logic [5:0] FUNC_SLT  = 6'b101010;
  localparam logic [5:0] FUNC_SLTU = 6'b101011;
  localparam logic [5:0] FUNC_BLTZ = 6'b111000;
  localparam logic [5:0] FUNC_BGEZ = 6'b111001;
  localparam logic [5:0] FUNC_BEQ  = 6'b111100;
  localparam logic [5:0] FUNC_BNE  = 6'b111101;
  localparam logic [5:0] FUNC_BLEZ = 6'b111110;
  localparam logic [5:0] FUNC_BGTZ = 6'b111111;

endpackage

// File: rtl/alu_branch_cmp.sv
// Combinational branch-taken decision; 0 for any non-branch function code.
module alu_branch_cmp
  import alu_pkg::*;
(
  input  logic [5:0]  func_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        taken_o
);

  logic a_neg;
  logic a_zero;
  logic a_eq_b;

  assign a_neg  = a_i[31];
  assign a_zero = (a_i == 32'd0);
  assign a_eq_b = (a_i == b_i);

  always_comb begin
    taken_o = 1'b0;
    case (func_i)
      FUNC_BLTZ: taken_o = a_neg;
      FUNC_BGEZ: taken_o = ~a_neg;
      FUNC_BEQ:  taken_o = a_eq_b;
      FUNC_BNE:  taken_o = ~a_eq_b;
      FUNC_BLEZ: taken_o = a_neg | a_zero;
      FUNC_BGTZ: taken_o = ~a_neg & ~a_zero;
      default:   taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_32bit.sv
// Registered 32-bit MIPS-style ALU: result mux plus output registers, one-cycle latency.
module alu_32bit
  import alu_pkg::*;
(
  input  logic        Clk_in,
  input  logic        Rst_n_in,
  input  logic [5:0]  Func_in,
  input  logic [31:0] A_in,
  input  logic [31:0] B_in,
  output logic [31:0] O_out,
  output logic        Branch_out,
  output logic        Jump_out
);

  logic [31:0] o_d, o_q;
  logic        branch_d, branch_q;
  logic        jump_d, jump_q;
  logic        taken;
  logic [4:0]  shamt;

  assign shamt = B_in[4:0];

  alu_branch_cmp u_branch_cmp (
    .func_i  (Func_in),
    .a_i     (A_in),
    .b_i     (B_in),
    .taken_o (taken)
  );

  always_comb begin
    o_d      = 32'd0;
    branch_d = taken;
    jump_d   = 1'b0;
    case (Func_in)
      FUNC_ADD, FUNC_ADDU: o_d = A_in + B_in;
      FUNC_SUB, FUNC_SUBU: o_d = A_in - B_in;
      FUNC_AND:            o_d = A_in & B_in;
      FUNC_OR:             o_d = A_in | B_in;
      FUNC_XOR:            o_d = A_in ^ B_in;
      FUNC_NOR:            o_d = ~(A_in | B_in);
      FUNC_SLT:            o_d = {31'd0, $signed(A_in) < $signed(B_in)};
      FUNC_SLTU:           o_d = {31'd0, A_in < B_in};
      FUNC_SLL:            o_d = A_in << shamt;
      FUNC_SRL:            o_d = A_in >> shamt;
      FUNC_SRA:            o_d = $unsigned($signed(A_in) >>> shamt);
      FUNC_JR: begin
        o_d    = A_in;
        jump_d = 1'b1;
      end
      // Branches pass A through as the result.
      FUNC_BLTZ, FUNC_BGEZ, FUNC_BEQ, FUNC_BNE, FUNC_BLEZ, FUNC_BGTZ: o_d = A_in;
      default:             o_d = 32'd0;
    endcase
  end

  always_ff @(posedge Clk_in or negedge Rst_n_in) begin
    if (!Rst_n_in) begin
      o_q      <= 32'd0;
      branch_q <= 1'b0;
      jump_q   <= 1'b0;
    end else begin
      o_q      <= o_d;
      branch_q <= branch_d;
      jump_q   <= jump_d;
    end
  end

  assign O_out      = o_q;
  assign Branch_out = branch_q;
  assign Jump_out   = jump_q;

endmodule

// File: tb/tb_alu_32bit.sv
// Self-checking bench for alu_32bit: directed boundary cases then random vectors vs. a model.
module tb_alu_32bit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  func;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] o_out;
  logic        branch_out;
  logic        jump_out;

  int n_vec = 0;
  int n_err = 0;

  alu_32bit dut (
    .Clk_in     (clk),
    .Rst_n_in   (rst_n),
    .Func_in    (func),
    .A_in       (a),
    .B_in       (b),
    .O_out      (o_out),
    .Branch_out (branch_out),
    .Jump_out   (jump_out)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] CODES [20] = '{
    6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101, 6'b100110,
    6'b100111, 6'b101010, 6'b101011, 6'b000000, 6'b000010, 6'b000011, 6'b001000,
    6'b111000, 6'b111001, 6'b111100, 6'b111101, 6'b111110, 6'b111111
  };

  // Reference model from the instruction semantics, using wide arithmetic.
  function automatic void model(input logic [5:0] f, input logic [31:0] ma, input logic [31:0] mb,
                                output logic [31:0] o, output logic br, output logic jp);
    longint sa, sb;
    longint unsigned ua, ub, t;
    logic [63:0] ext;
    int sh;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    ua = {32'd0, ma};
    ub = {32'd0, mb};
    sh = int'(mb % 32);
    o  = 32'd0;
    br = 1'b0;
    jp = 1'b0;
    case (f)
      6'b100000, 6'b100001: begin t = ua + ub; o = t[31:0]; end
      6'b100010, 6'b100011: begin t = ua + 64'h1_0000_0000 - ub; o = t[31:0]; end
      6'b100100: o = ma & mb;
      6'b100101: o = ma | mb;
      6'b100110: o = ma ^ mb;
      6'b100111: o = ~(ma | mb);
      6'b101010: o = (sa < sb) ? 32'd1 : 32'd0;
      6'b101011: o = (ua < ub) ? 32'd1 : 32'd0;
      6'b000000: begin t = ua * (64'd1 << sh); o = t[31:0]; end
      6'b000010: begin t = ua / (64'd1 << sh); o = t[31:0]; end
      6'b000011: begin ext = {{32{ma[31]}}, ma}; ext = ext >> sh; o = ext[31:0]; end
      6'b001000: begin o = ma; jp = 1'b1; end
      6'b111000: begin o = ma; br = (sa < 0); end
      6'b111001: begin o = ma; br = (sa >= 0); end
      6'b111100: begin o = ma; br = (ma == mb); end
      6'b111101: begin o = ma; br = (ma != mb); end
      6'b111110: begin o = ma; br = (sa <= 0); end
      6'b111111: begin o = ma; br = (sa > 0); end
      default: ;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply(input string tag, input logic [5:0] f, input logic [31:0] ta,
                       input logic [31:0] tb);
    logic [31:0] eo;
    logic eb, ej;
    @(negedge clk);
    func = f;
    a    = ta;
    b    = tb;
    @(posedge clk);
    #1;
    model(f, ta, tb, eo, eb, ej);
    check({tag, " O_out"}, o_out, eo);
    check({tag, " Branch_out"}, {31'd0, branch_out}, {31'd0, eb});
    check({tag, " Jump_out"}, {31'd0, jump_out}, {31'd0, ej});
  endtask

  initial begin
    func  = 6'b100000;
    a     = 32'd0;
    b     = 32'd0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("reset O_out", o_out, 32'd0);
    check("reset Branch_out", {31'd0, branch_out}, 32'd0);
    check("reset Jump_out", {31'd0, jump_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases with hard constants alongside the model.
    apply("bltz", 6'b111000, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("bltz const O", o_out, 32'hFFFFFFFF);
    check("bltz const br", {31'd0, branch_out}, 32'd1);
    apply("bgez", 6'b111001, 32'd0, 32'd0);
    check("bgez const br", {31'd0, branch_out}, 32'd1);
    apply("beq", 6'b111100, 32'd0, 32'd1);
    check("beq const br", {31'd0, branch_out}, 32'd0);
    apply("bne", 6'b111101, 32'd0, 32'd1);
    check("bne const br", {31'd0, branch_out}, 32'd1);
    apply("blez0", 6'b111110, 32'd0, 32'd0);
    check("blez0 const br", {31'd0, branch_out}, 32'd1);
    apply("bgtzF", 6'b111111, 32'h0000000F, 32'd0);
    check("bgtzF const br", {31'd0, branch_out}, 32'd1);
    apply("bgtz0", 6'b111111, 32'd0, 32'd0);
    check("bgtz0 const br", {31'd0, branch_out}, 32'd0);
    apply("bltz_min", 6'b111000, 32'h80000000, 32'd0);
    check("bltz_min const br", {31'd0, branch_out}, 32'd1);
    apply("add_ovf", 6'b100000, 32'h7FFFFFFF, 32'd1);
    check("add_ovf const O", o_out, 32'h80000000);
    apply("sub_wrap", 6'b100010, 32'd0, 32'd1);
    check("sub_wrap const O", o_out, 32'hFFFFFFFF);
    apply("slt", 6'b101010, 32'hFFFFFFFF, 32'd1);
    check("slt const O", o_out, 32'd1);
    apply("sltu", 6'b101011, 32'hFFFFFFFF, 32'd1);
    check("sltu const O", o_out, 32'd0);
    apply("sra31", 6'b000011, 32'h80000000, 32'd31);
    check("sra31 const O", o_out, 32'hFFFFFFFF);
    apply("sll0", 6'b000000, 32'hDEADBEEF, 32'hFFFFFFE0);
    check("sll0 const O", o_out, 32'hDEADBEEF);
    apply("jr", 6'b001000, 32'h00400020, 32'd5);
    check("jr const O", o_out, 32'h00400020);
    check("jr const jump", {31'd0, jump_out}, 32'd1);
    apply("unlisted", 6'b111010, 32'h12345678, 32'h12345678);
    check("unlisted const O", o_out, 32'd0);

    // Reset mid-run with ADD active: outputs clear before the next edge.
    apply("pre_rst_add", 6'b100000, 32'd5, 32'd7);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst O_out", o_out, 32'd0);
    @(posedge clk);
    #1;
    check("held_rst O_out", o_out, 32'd0);
    check("held_rst Branch_out", {31'd0, branch_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apply("post_rst_add", 6'b100000, 32'd5, 32'd7);
    check("post_rst const O", o_out, 32'd12);

    // Random vectors, biased toward branch-relevant operands.
    for (int i = 0; i < 400; i++) begin
      logic [5:0]  rf;
      logic [31:0] ra, rb;
      rf = (($urandom % 8) == 0) ? 6'($urandom) : CODES[$urandom_range(0, 19)];
      ra = $urandom;
      rb = $urandom;
      case ($urandom % 6)
        0: rb = ra;
        1: ra = 32'd0;
        2: ra = 32'h80000000;
        default: ;
      endcase
      apply("rnd", rf, ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
